// File: rtl/fxp8s_out_collector_if.sv
// Stream bundle between the PE array, the output collector and the writeback
// loader. The master side is the collector itself; the slave side is the
// surrounding environment (PE array upstream, writeback downstream).
interface fxp8s_out_collector_if #(
    parameter int COLS  = 3,
    parameter int WIDTH = 8
);
    logic                    relu_en;
    logic                    en_in_data;
    logic                    rdy_in_data;
    logic [WIDTH-1:0]        in_data;
    logic                    en_out_row;
    logic                    rdy_out_row;
    logic [COLS*WIDTH-1:0]   out_row_data;
    logic [1:0]              out_row_idx;
    logic                    out_mat_done;
    logic [WIDTH-2:0]        out_max_mag;
    logic [7:0]              mat_cnt;

    modport master (
        input  relu_en, en_in_data, in_data, rdy_out_row,
        output rdy_in_data, en_out_row, out_row_data, out_row_idx,
               out_mat_done, out_max_mag, mat_cnt
    );

    modport slave (
        output relu_en, en_in_data, in_data, rdy_out_row,
        input  rdy_in_data, en_out_row, out_row_data, out_row_idx,
               out_mat_done, out_max_mag, mat_cnt
    );
endinterface

// File: rtl/fxp8s_out_collector.sv
// Output collector for the 3x3 fxp8s PE array: gathers one row-major result
// matrix (optionally ReLU'd in sign-magnitude), tracks its peak magnitude and
// replays it as packed row words on a second en/rdy stream.
module fxp8s_out_collector #(
    parameter int ROWS  = 3,
    parameter int COLS  = 3,
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    fxp8s_out_collector_if.master bus
);
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic                    rdy_q, rdy_d;
    logic [1:0]              in_row_q, in_row_d;
    logic [CW-1:0]           in_col_q, in_col_d;
    logic [1:0]              out_idx_q, out_idx_d;
    logic                    relu_q, relu_d;
    logic [WIDTH-2:0]        max_q, max_d;
    logic [7:0]              mat_cnt_q, mat_cnt_d;
    logic [COLS*WIDTH-1:0]   mat_q [ROWS];
    logic [COLS*WIDTH-1:0]   mat_d [ROWS];

    logic                    in_xfer;
    logic                    out_xfer;
    logic                    first_elem;
    logic                    relu_eff;
    logic [WIDTH-1:0]        proc;

    // Element conditioning: the ReLU setting for element (0,0) comes straight
    // from the pin because the latch only captures it on that same transfer.
    always_comb begin
        in_xfer    = bus.en_in_data & rdy_q;
        out_xfer   = (state_q == DRAIN) & bus.rdy_out_row;
        first_elem = (in_row_q == 2'd0) && (in_col_q == '0);
        relu_eff   = first_elem ? bus.relu_en : relu_q;
        proc       = (relu_eff && bus.in_data[WIDTH-1]) ? '0 : bus.in_data;
    end

    // Next-state logic for the fill/drain sequencer and all its counters.
    always_comb begin
        state_d   = state_q;
        rdy_d     = rdy_q;
        in_row_d  = in_row_q;
        in_col_d  = in_col_q;
        out_idx_d = out_idx_q;
        relu_d    = relu_q;
        max_d     = max_q;
        mat_cnt_d = mat_cnt_q;
        mat_d     = mat_q;

        case (state_q)
            FILL: begin
                rdy_d = 1'b1;
                if (in_xfer) begin
                    mat_d[in_row_q][in_col_q*WIDTH +: WIDTH] = proc;
                    if (first_elem) relu_d = bus.relu_en;
                    if (proc[WIDTH-2:0] > max_q) max_d = proc[WIDTH-2:0];
                    if (in_col_q == CW'(COLS-1)) begin
                        in_col_d = '0;
                        if (in_row_q == 2'(ROWS-1)) begin
                            in_row_d = 2'd0;
                            state_d  = DRAIN;
                            rdy_d    = 1'b0;
                        end else begin
                            in_row_d = in_row_q + 2'd1;
                        end
                    end else begin
                        in_col_d = in_col_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                rdy_d = 1'b0;
                if (out_xfer) begin
                    if (out_idx_q == 2'(ROWS-1)) begin
                        out_idx_d = 2'd0;
                        mat_cnt_d = mat_cnt_q + 8'd1;
                        max_d     = '0;
                        state_d   = FILL;
                        rdy_d     = 1'b1;
                    end else begin
                        out_idx_d = out_idx_q + 2'd1;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    // State register; reset discards any partial matrix and clears the buffer.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= FILL;
            rdy_q     <= 1'b0;
            in_row_q  <= 2'd0;
            in_col_q  <= '0;
            out_idx_q <= 2'd0;
            relu_q    <= 1'b0;
            max_q     <= '0;
            mat_cnt_q <= 8'd0;
            for (int r = 0; r < ROWS; r++) mat_q[r] <= '0;
        end else begin
            state_q   <= state_d;
            rdy_q     <= rdy_d;
            in_row_q  <= in_row_d;
            in_col_q  <= in_col_d;
            out_idx_q <= out_idx_d;
            relu_q    <= relu_d;
            max_q     <= max_d;
            mat_cnt_q <= mat_cnt_d;
            for (int r = 0; r < ROWS; r++) mat_q[r] <= mat_d[r];
        end
    end

    // All outputs come from registers, so downstream backpressure never
    // reaches rdy_in_data and upstream valid never reaches en_out_row.
    always_comb begin
        bus.rdy_in_data  = rdy_q;
        bus.en_out_row   = (state_q == DRAIN);
        bus.out_row_data = (state_q == DRAIN) ? mat_q[out_idx_q] : '0;
        bus.out_row_idx  = out_idx_q;
        bus.out_mat_done = (state_q == DRAIN) && (out_idx_q == 2'(ROWS-1));
        bus.out_max_mag  = max_q;
        bus.mat_cnt      = mat_cnt_q;
    end
endmodule

// File: tb/tb_fxp8s_out_collector.sv
// Bench for fxp8s_out_collector: directed matrices plus randomized traffic,
// checked every cycle against a queue-based model of the collector.
module tb_fxp8s_out_collector;
    localparam int ROWS  = 3;
    localparam int COLS  = 3;
    localparam int WIDTH = 8;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    fxp8s_out_collector_if #(.COLS(COLS), .WIDTH(WIDTH)) bus ();

    fxp8s_out_collector #(.ROWS(ROWS), .COLS(COLS), .WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int rdy_mode = 0;   // 0: always ready, 1: random, 2: stalled

    // Model state
    logic [7:0]  m_elems[$];
    bit          m_relu = 1'b0;
    bit          m_fill = 1'b1;
    int          m_r    = 0;
    logic [23:0] m_rows [3];
    int          m_max  = 0;
    int          m_cnt  = 0;
    bit          m_hold = 1'b1;
    int          in_xfer_cnt = 0;

    logic [23:0] row_log[$];
    int          max_log[$];
    logic [7:0]  stim [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] logged_row(input int i);
        if (row_log.size() > i) return {8'h00, row_log[i]};
        return 32'hxxxxxxxx;
    endfunction

    function automatic logic [31:0] logged_max(input int i);
        if (max_log.size() > i) return max_log[i];
        return 32'hxxxxxxxx;
    endfunction

    // Per-cycle compare against the model, then advance the model by whatever
    // transfers happen at the coming posedge.
    always @(negedge clk) begin
        bit en_e, rdy_e;
        logic [7:0] p;
        en_e  = !m_fill;
        rdy_e = m_fill && !m_hold;
        chk("rdy_in_data", {31'd0, bus.rdy_in_data}, {31'd0, rdy_e});
        chk("en_out_row", {31'd0, bus.en_out_row}, {31'd0, en_e});
        chk("mat_cnt", {24'd0, bus.mat_cnt}, m_cnt);
        chk("out_max_mag", {25'd0, bus.out_max_mag}, m_max);
        if (en_e) begin
            chk("out_row_data", {8'd0, bus.out_row_data}, {8'd0, m_rows[m_r]});
            chk("out_row_idx", {30'd0, bus.out_row_idx}, m_r);
            chk("out_mat_done", {31'd0, bus.out_mat_done}, (m_r == ROWS-1) ? 32'd1 : 32'd0);
        end else begin
            chk("out_mat_done_idle", {31'd0, bus.out_mat_done}, 32'd0);
        end

        if (rstn !== 1'b1) begin
            m_elems.delete();
            m_fill = 1'b1; m_r = 0; m_max = 0; m_cnt = 0; m_hold = 1'b1;
        end else begin
            m_hold = 1'b0;
            if (rdy_e && bus.en_in_data === 1'b1) begin
                in_xfer_cnt++;
                if (m_elems.size() == 0) m_relu = bus.relu_en;
                p = (m_relu && bus.in_data[7]) ? 8'h00 : bus.in_data;
                m_elems.push_back(p);
                if (int'(p[6:0]) > m_max) m_max = int'(p[6:0]);
                if (m_elems.size() == ROWS*COLS) begin
                    for (int r = 0; r < ROWS; r++)
                        m_rows[r] = {m_elems[3*r+2], m_elems[3*r+1], m_elems[3*r]};
                    m_fill = 1'b0;
                    m_r    = 0;
                end
            end
            if (en_e && bus.rdy_out_row === 1'b1) begin
                row_log.push_back(bus.out_row_data);
                max_log.push_back(int'(bus.out_max_mag));
                if (m_r == ROWS-1) begin
                    m_cnt = (m_cnt + 1) % 256;
                    m_fill = 1'b1;
                    m_elems.delete();
                    m_max = 0;
                    m_r   = 0;
                end else begin
                    m_r++;
                end
            end
        end
    end

    // Downstream ready driver
    initial begin
        bus.rdy_out_row = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.rdy_out_row = 1'b1;
                1:       bus.rdy_out_row = 1'($urandom_range(0, 1));
                default: bus.rdy_out_row = 1'b0;
            endcase
        end
    end

    task automatic send(input int n, input bit r0, input bit gaps, input bit rmix);
        for (int i = 0; i < n; i++) begin
            bit acc;
            acc = 1'b0;
            bus.relu_en    = (i == 0 || !rmix) ? r0 : 1'($urandom_range(0, 1));
            bus.en_in_data = 1'b1;
            bus.in_data    = stim[i];
            for (int k = 0; k < 400 && !acc; k++) begin
                @(negedge clk);
                acc = (bus.rdy_in_data === 1'b1);
                @(posedge clk);
                #1;
            end
            if (!acc) begin
                n_tests++; n_fail++;
                $display("FAIL send_timeout: element %0d got no rdy_in_data, expected acceptance", i);
                bus.en_in_data = 1'b0;
                return;
            end
            if (gaps) begin
                bus.en_in_data = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        bus.en_in_data = 1'b0;
    endtask

    task automatic wait_cnt(input int target);
        int k;
        k = 0;
        while (m_cnt != target && k < 600) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (m_cnt != target) begin
            n_tests++; n_fail++;
            $display("FAIL drain_timeout: matrix count %0d expected %0d", m_cnt, target);
        end
    endtask

    task automatic seq_stim(input logic [7:0] base);
        for (int i = 0; i < 9; i++) stim[i] = base + 8'(i);
    endtask

    task automatic check_rows(input string tag, input logic [23:0] r0, input logic [23:0] r1,
                              input logic [23:0] r2);
        chk({tag, "_row0"}, logged_row(0), {8'd0, r0});
        chk({tag, "_row1"}, logged_row(1), {8'd0, r1});
        chk({tag, "_row2"}, logged_row(2), {8'd0, r2});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        bus.en_in_data = 1'b0;
        bus.in_data    = 8'h00;
        bus.relu_en    = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_en_out_row", {31'd0, bus.en_out_row}, 32'd0);
        chk("rst_rdy_in_data", {31'd0, bus.rdy_in_data}, 32'd0);
        chk("rst_out_row_data", {8'd0, bus.out_row_data}, 32'd0);
        chk("rst_out_row_idx", {30'd0, bus.out_row_idx}, 32'd0);
        chk("rst_mat_cnt", {24'd0, bus.mat_cnt}, 32'd0);
        @(posedge clk);
        #1 rstn = 1'b1;

        // Basic
        seq_stim(8'h01);
        row_log.delete(); max_log.delete();
        send(9, 1'b0, 1'b0, 1'b0);
        wait_cnt(1);
        check_rows("basic", 24'h030201, 24'h060504, 24'h090807);
        chk("basic_max", logged_max(2), 32'h09);
        chk("basic_mat_cnt", {24'd0, bus.mat_cnt}, 32'd1);

        // ReLU on, then the same stream with ReLU off
        stim = '{8'h85, 8'h02, 8'h80, 8'hFF, 8'h10, 8'h03, 8'h81, 8'h7F, 8'h00};
        row_log.delete(); max_log.delete();
        send(9, 1'b1, 1'b0, 1'b0);
        wait_cnt(2);
        check_rows("relu", 24'h000200, 24'h031000, 24'h007F00);
        chk("relu_max", logged_max(0), 32'h7F);
        row_log.delete(); max_log.delete();
        send(9, 1'b0, 1'b0, 1'b0);
        wait_cnt(3);
        chk("norelu_row0", logged_row(0), 32'h00800285);
        chk("norelu_max", logged_max(0), 32'h7F);

        // Backpressure with a stray element held during DRAIN
        rdy_mode = 2;
        seq_stim(8'h01);
        row_log.delete(); max_log.delete();
        send(9, 1'b0, 1'b0, 1'b0);
        seq_stim(8'h11);
        bus.en_in_data = 1'b1;
        bus.in_data    = stim[0];
        c0 = in_xfer_cnt;
        repeat (5) begin
            @(negedge clk);
            chk("bp_row0_hold", {8'd0, bus.out_row_data}, 32'h00030201);
            chk("bp_rdy_in_low", {31'd0, bus.rdy_in_data}, 32'd0);
        end
        chk("bp_no_accept", in_xfer_cnt - c0, 32'd0);
        @(posedge clk);
        #1 rdy_mode = 0;
        send(9, 1'b0, 1'b0, 1'b0);
        wait_cnt(5);
        check_rows("bp", 24'h030201, 24'h060504, 24'h090807);
        chk("bp_next_row0", logged_row(3), 32'h00131211);

        // Upstream gaps
        seq_stim(8'h01);
        row_log.delete(); max_log.delete();
        c0 = in_xfer_cnt;
        send(9, 1'b0, 1'b1, 1'b0);
        chk("gaps_xfers", in_xfer_cnt - c0, 32'd9);
        wait_cnt(6);
        check_rows("gaps", 24'h030201, 24'h060504, 24'h090807);

        // Reset mid-FILL
        seq_stim(8'h21);
        send(5, 1'b0, 1'b0, 1'b0);
        rstn = 1'b0;
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        chk("mrst_en_out_row", {31'd0, bus.en_out_row}, 32'd0);
        chk("mrst_rdy_in_data", {31'd0, bus.rdy_in_data}, 32'd0);
        chk("mrst_out_row_data", {8'd0, bus.out_row_data}, 32'd0);
        chk("mrst_out_max_mag", {25'd0, bus.out_max_mag}, 32'd0);
        chk("mrst_mat_cnt", {24'd0, bus.mat_cnt}, 32'd0);
        seq_stim(8'h01);
        row_log.delete(); max_log.delete();
        send(9, 1'b0, 1'b0, 1'b0);
        wait_cnt(1);
        check_rows("mrst", 24'h030201, 24'h060504, 24'h090807);
        chk("mrst_mat_cnt_after", {24'd0, bus.mat_cnt}, 32'd1);

        // Back-to-back matrices, relu_en toggled mid-matrix
        for (int m = 0; m < 3; m++) begin
            for (int i = 0; i < 9; i++) stim[i] = 8'($urandom_range(0, 255));
            send(9, 1'(m % 2), 1'b0, 1'b1);
        end
        wait_cnt(4);
        chk("b2b_mat_cnt", {24'd0, bus.mat_cnt}, 32'd4);

        // Randomized traffic with random downstream stalls
        rdy_mode = 1;
        for (int m = 0; m < 20; m++) begin
            for (int i = 0; i < 9; i++) stim[i] = 8'($urandom_range(0, 255));
            send(9, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
        end
        wait_cnt(24);
        rdy_mode = 0;
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fxp8s_out_collector.md
Name: fxp8s_out_collector

Overview:
- Downstream stage of the 3x3 fxp8s PE array.
- Consumes the array's element-serial result stream (row-major, 9 elements per matrix, en/rdy handshake), optionally applies sign-magnitude ReLU, and buffers one full result matrix.
- Re-emits the matrix as three packed row words on a second en/rdy stream for the writeback / next-layer loader.
- Tracks the per-matrix maximum magnitude for downstream requantisation.

Parameters:
- ROWS, 3, result rows per matrix.
- COLS, 3, result columns per matrix.
- WIDTH, 8, element width; sign-magnitude, bit WIDTH-1 is the sign, LSB weight 2^-3.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rstn  input  1  reset, synchronous, active-low.
- relu_en  input  1  1 = clamp negative elements to 0; sampled on the first element of each matrix.
- en_in_data  input  1  upstream element valid; connects to the PE array's en_out_data.
- rdy_in_data  output  1  collector can accept an element; connects to the PE array's rdy_out_data.
- in_data  input  WIDTH  result element, row-major order.
- en_out_row  output  1  packed row valid.
- rdy_out_row  input  1  downstream accepts the row.
- out_row_data  output  COLS*WIDTH  packed row; column c occupies bits [c*WIDTH +: WIDTH].
- out_row_idx  output  2  index of the row on out_row_data.
- out_mat_done  output  1  high together with en_out_row on the last row (ROWS-1).
- out_max_mag  output  WIDTH-1  maximum post-ReLU magnitude of the matrix being drained.
- mat_cnt  output  8  matrices fully drained since reset, wraps 255->0.

Behaviour:
- Reset: synchronous, active-low.
  - Outputs: rdy_in_data=0, en_out_row=0, out_row_data=0, out_row_idx=0, out_mat_done=0, out_max_mag=0, mat_cnt=0.
  - Internal: FSM=FILL, all counters 0, buffer cleared to 0.
  - Reset asserted mid-FILL or mid-DRAIN discards the partial matrix; no row is emitted afterwards.
- Input transfer occurs when en_in_data & rdy_in_data.
- Output transfer occurs when en_out_row & rdy_out_row.
- FSM, two states:
  - FILL:
    - rdy_in_data=1 from the first cycle after rstn is released; it is a registered output.
    - Each input transfer writes the processed element to buf[in_row][in_col].
    - in_col increments, wrapping at COLS-1; in_row increments on column wrap.
    - On the transfer of element (ROWS-1, COLS-1): go to DRAIN. rdy_in_data=0 from the next cycle.
  - DRAIN:
    - rdy_in_data=0; en_out_row=1.
    - out_row_data = buf[out_row_idx], driven from registers.
    - Each output transfer advances out_row_idx.
    - On the transfer of row ROWS-1: mat_cnt+1, out_row_idx=0, clear the max tracker, return to FILL. rdy_in_data=1 in the next cycle.
    - While rdy_out_row=0, en_out_row, out_row_data, out_row_idx and out_mat_done hold stable.
- Element processing, combinational before the buffer write:
  - relu_en=1 and sign=1 -> element written as 0x00.
  - relu_en=0 -> element written unchanged, including 0x80 (negative zero).
  - relu_en is latched on element (0,0); the latched value applies to the whole matrix. Toggling it mid-matrix has no effect until the next matrix.
- Max tracker:
  - On each input transfer, max_mag <= max(max_mag, processed[WIDTH-2:0]). Magnitude only; sign is ignored.
  - out_max_mag is valid throughout DRAIN.
- Latency:
  - Last element accepted at cycle t -> en_out_row=1 at t+1.
  - Minimum matrix turnaround is 9 input cycles + 3 output cycles.
- No combinational path from rdy_out_row to rdy_in_data, or from en_in_data to en_out_row.
- Stray input: en_in_data high during DRAIN is not accepted (rdy_in_data=0); the element is held off upstream, never dropped.

Test Plan:
- Basic: relu_en=0, stream 0x01..0x09 with rdy_out_row=1.
  - Rows 0x030201, 0x060504, 0x090807 with idx 0,1,2.
  - out_mat_done only on idx 2; out_max_mag=0x09; mat_cnt=1.
- ReLU: relu_en=1, stream 0x85,0x02,0x80,0xFF,0x10,0x03,0x81,0x7F,0x00.
  - Rows 0x000200, 0x031000, 0x007F00; out_max_mag=0x7F.
  - Same stream with relu_en=0 -> row 0 = 0x800285; out_max_mag=0x7F.
- Backpressure: hold rdy_out_row=0 for 5 cycles after DRAIN entry.
  - Row 0 stable for 5 cycles; rdy_in_data stays 0.
  - en_in_data held high during DRAIN is not accepted until the cycle after the row-2 transfer.
- Upstream gaps: toggle en_in_data 1/0 every cycle.
  - Same packed output as the Basic case; 9 transfers counted exactly.
- Reset mid-operation: drive rstn=0 for 1 cycle after 5 elements.
  - All outputs return to reset values; the next 9 elements form a clean matrix; mat_cnt counts only that matrix.
- Back-to-back: 3 matrices with relu_en toggled between them.
  - Each matrix uses the relu_en value latched at its element (0,0); mat_cnt=3; out_max_mag resets per matrix.
